// File: rtl/y86_pkg.sv
// Shared Y86-64 constants: instruction codes, register ids, status codes, CC reset value.
package y86_pkg;

   localparam logic [3:0] IHALT   = 4'h0;
   localparam logic [3:0] INOP    = 4'h1;
   localparam logic [3:0] IRRMOVQ = 4'h2;
   localparam logic [3:0] IIRMOVQ = 4'h3;
   localparam logic [3:0] IRMMOVQ = 4'h4;
   localparam logic [3:0] IMRMOVQ = 4'h5;
   localparam logic [3:0] IOPQ    = 4'h6;
   localparam logic [3:0] IJXX    = 4'h7;
   localparam logic [3:0] ICALL   = 4'h8;
   localparam logic [3:0] IRET    = 4'h9;
   localparam logic [3:0] IPUSHQ  = 4'hA;
   localparam logic [3:0] IPOPQ   = 4'hB;

   localparam logic [3:0] RNONE   = 4'hF;
   localparam logic [3:0] RRSP    = 4'h4;

   localparam logic [2:0] SAOK    = 3'd1;
   localparam logic [2:0] SHLT    = 3'd2;
   localparam logic [2:0] SADR    = 3'd3;
   localparam logic [2:0] SINS    = 3'd4;

   // {zf,sf,of} after reset
   localparam logic [2:0] CC_RESET = 3'b100;

endpackage

// File: rtl/seq_state_update_if.sv
// Bundle between the SEQ front end (fetch/decode/execute/memory) and the state-update block.
interface seq_state_update_if;
   logic        step_en;
   logic [3:0]  icode;
   logic [3:0]  ifun;
   logic [3:0]  rA;
   logic [3:0]  rB;
   logic        instr_valid;
   logic        imem_error;
   logic        dmem_error;
   logic        Cnd;
   logic        zf_in;
   logic        sf_in;
   logic        of_in;
   logic [63:0] valE;
   logic [63:0] valM;
   logic [63:0] valC;
   logic [63:0] valP;
   logic [63:0] valA;
   logic [63:0] valB;
   logic        cc_zf;
   logic        cc_sf;
   logic        cc_of;
   logic [63:0] pc;
   logic [2:0]  stat;
   logic        halted;

   modport master (
      output step_en, icode, ifun, rA, rB, instr_valid, imem_error, dmem_error,
             Cnd, zf_in, sf_in, of_in, valE, valM, valC, valP,
      input  valA, valB, cc_zf, cc_sf, cc_of, pc, stat, halted
   );

   modport slave (
      input  step_en, icode, ifun, rA, rB, instr_valid, imem_error, dmem_error,
             Cnd, zf_in, sf_in, of_in, valE, valM, valC, valP,
      output valA, valB, cc_zf, cc_sf, cc_of, pc, stat, halted
   );
endinterface

// File: rtl/y86_regfile.sv
// 15 x 64-bit Y86-64 register file: two async read ports, two write ports (M wins on collision).
module y86_regfile
   import y86_pkg::*;
#(
   parameter logic [63:0] RSP_INIT = 64'h0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        we,
   input  logic [3:0]  src_a,
   input  logic [3:0]  src_b,
   output logic [63:0] val_a,
   output logic [63:0] val_b,
   input  logic [3:0]  dst_e,
   input  logic [63:0] val_e,
   input  logic [3:0]  dst_m,
   input  logic [63:0] val_m
);

   logic [63:0] regs_r [0:14];

   // Register storage; E written first so an M write to the same index overrides it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 15; i++) begin
            regs_r[i] <= (i == 4) ? RSP_INIT : 64'h0;
         end
      end else if (we) begin
         if (dst_e != RNONE) begin
            regs_r[dst_e] <= val_e;
         end
         if (dst_m != RNONE) begin
            regs_r[dst_m] <= val_m;
         end
      end
   end

   // Combinational read ports; index F reads as zero.
   always_comb begin
      if (src_a == RNONE) begin
         val_a = 64'h0;
      end else begin
         val_a = regs_r[src_a];
      end
      if (src_b == RNONE) begin
         val_b = 64'h0;
      end else begin
         val_b = regs_r[src_b];
      end
   end

endmodule

// File: rtl/seq_state_update.sv
// SEQ architectural-state commit: register file, condition codes, PC and status.
module seq_state_update
   import y86_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [63:0] RSP_INIT = 64'h0
) (
   input  logic               clk,
   input  logic               rst_n,
   seq_state_update_if.slave  bus
);

   logic [3:0]  src_a_s, src_b_s, dst_e_s, dst_m_s;
   logic [2:0]  stat_next_s;
   logic [63:0] pc_next_s;
   logic        commit_s, wr_ok_s;
   logic [63:0] pc_r;
   logic [2:0]  stat_r;
   logic [2:0]  cc_r;
   logic        halted_r;
   logic        unused_ifun_s;

   // ifun is carried for debug visibility only; Cnd already encodes its effect.
   assign unused_ifun_s = ^bus.ifun;

   assign commit_s = bus.step_en && (stat_r == SAOK);
   assign wr_ok_s  = commit_s && (stat_next_s == SAOK);

   // Source and destination register selection from icode.
   always_comb begin
      case (bus.icode)
         IRRMOVQ, IRMMOVQ, IOPQ, IPUSHQ: src_a_s = bus.rA;
         IRET, IPOPQ:                    src_a_s = RRSP;
         default:                        src_a_s = RNONE;
      endcase
      case (bus.icode)
         IRMMOVQ, IMRMOVQ, IOPQ:         src_b_s = bus.rB;
         ICALL, IRET, IPUSHQ, IPOPQ:     src_b_s = RRSP;
         default:                        src_b_s = RNONE;
      endcase
      case (bus.icode)
         IIRMOVQ, IOPQ:                  dst_e_s = bus.rB;
         IRRMOVQ:                        dst_e_s = bus.Cnd ? bus.rB : RNONE;
         ICALL, IRET, IPUSHQ, IPOPQ:     dst_e_s = RRSP;
         default:                        dst_e_s = RNONE;
      endcase
      case (bus.icode)
         IMRMOVQ, IPOPQ:                 dst_m_s = bus.rA;
         default:                        dst_m_s = RNONE;
      endcase
   end

   // Status of the instruction being committed, highest-priority fault first.
   always_comb begin
      if (bus.imem_error || bus.dmem_error) begin
         stat_next_s = SADR;
      end else if (!bus.instr_valid || (bus.icode > IPOPQ)) begin
         stat_next_s = SINS;
      end else if (bus.icode == IHALT) begin
         stat_next_s = SHLT;
      end else begin
         stat_next_s = SAOK;
      end
   end

   // Next PC selection.
   always_comb begin
      case (bus.icode)
         IJXX:    pc_next_s = bus.Cnd ? bus.valC : bus.valP;
         ICALL:   pc_next_s = bus.valC;
         IRET:    pc_next_s = bus.valM;
         default: pc_next_s = bus.valP;
      endcase
   end

   // PC, CC, status and halted commit; non-AOK status is sticky until reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r     <= RESET_PC;
         cc_r     <= CC_RESET;
         stat_r   <= SAOK;
         halted_r <= 1'b0;
      end else if (commit_s) begin
         stat_r   <= stat_next_s;
         halted_r <= (stat_next_s != SAOK);
         if (wr_ok_s) begin
            pc_r <= pc_next_s;
            if (bus.icode == IOPQ) begin
               cc_r <= {bus.zf_in, bus.sf_in, bus.of_in};
            end
         end
      end
   end

   y86_regfile #(.RSP_INIT(RSP_INIT)) u_regfile (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_ok_s),
      .src_a (src_a_s),
      .src_b (src_b_s),
      .val_a (bus.valA),
      .val_b (bus.valB),
      .dst_e (dst_e_s),
      .val_e (bus.valE),
      .dst_m (dst_m_s),
      .val_m (bus.valM)
   );

   assign bus.pc     = pc_r;
   assign bus.stat   = stat_r;
   assign bus.halted = halted_r;
   assign bus.cc_zf  = cc_r[2];
   assign bus.cc_sf  = cc_r[1];
   assign bus.cc_of  = cc_r[0];

endmodule

// File: tb/tb_seq_state_update.sv
// Directed-vector bench for seq_state_update with hand-computed expectations.
module tb_seq_state_update;

   localparam logic [63:0] T_RESET_PC = 64'h1000;
   localparam logic [63:0] T_RSP_INIT = 64'h01F0;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;
   logic [63:0] rd_v;

   seq_state_update_if bus ();

   seq_state_update #(.RESET_PC(T_RESET_PC), .RSP_INIT(T_RSP_INIT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic set_instr(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [63:0] ve, input logic [63:0] vm,
                            input logic [63:0] vc, input logic [63:0] vp, input logic cnd);
      bus.icode = ic;  bus.ifun = 4'h0; bus.rA = ra; bus.rB = rb;
      bus.valE = ve;   bus.valM = vm;   bus.valC = vc; bus.valP = vp;
      bus.Cnd  = cnd;
   endtask

   task automatic step();
      bus.step_en = 1'b1;
      @(posedge clk);
      #1;
      bus.step_en = 1'b0;
   endtask

   // Uses rrmovq's srcA=rA path with step_en low to peek a register.
   task automatic read_reg(input logic [3:0] r, output logic [63:0] v);
      bus.step_en = 1'b0;
      bus.icode = 4'h2;
      bus.rA = r;
      #1;
      v = bus.valA;
   endtask

   task automatic pulse_reset();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      rst_n = 1'b0;
      bus.step_en = 1'b0; bus.instr_valid = 1'b1;
      bus.imem_error = 1'b0; bus.dmem_error = 1'b0;
      bus.zf_in = 1'b0; bus.sf_in = 1'b0; bus.of_in = 1'b0;
      set_instr(4'h1, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0);
      #12;
      check("rst_pc", bus.pc, T_RESET_PC);
      check("rst_stat", {61'h0, bus.stat}, 64'd1);
      check("rst_halted", {63'h0, bus.halted}, 64'd0);
      check("rst_cc", {61'h0, bus.cc_zf, bus.cc_sf, bus.cc_of}, 64'd4);
      read_reg(4'h4, rd_v); check("rst_r4", rd_v, T_RSP_INIT);
      read_reg(4'h3, rd_v); check("rst_r3", rd_v, 64'h0);
      read_reg(4'hF, rd_v); check("rd_none", rd_v, 64'h0);
      @(negedge clk); rst_n = 1'b1;

      // 1 OPq
      set_instr(4'h6, 4'h2, 4'h3, 64'h5, 64'h0, 64'h0, 64'h0A, 1'b0);
      bus.zf_in = 1'b0; bus.sf_in = 1'b1; bus.of_in = 1'b0;
      step();
      read_reg(4'h3, rd_v); check("opq_r3", rd_v, 64'h5);
      check("opq_cc", {61'h0, bus.cc_zf, bus.cc_sf, bus.cc_of}, 64'd2);
      check("opq_pc", bus.pc, 64'h0A);

      // 2 jXX not taken then taken; flag inputs changed to show CC holds
      bus.zf_in = 1'b1; bus.sf_in = 1'b0; bus.of_in = 1'b1;
      set_instr(4'h7, 4'hF, 4'hF, 64'h0, 64'h0, 64'h100, 64'h20, 1'b0);
      step();
      check("jxx_nt_pc", bus.pc, 64'h20);
      set_instr(4'h7, 4'hF, 4'hF, 64'h0, 64'h0, 64'h100, 64'h20, 1'b1);
      step();
      check("jxx_t_pc", bus.pc, 64'h100);
      check("jxx_cc", {61'h0, bus.cc_zf, bus.cc_sf, bus.cc_of}, 64'd2);
      read_reg(4'h3, rd_v); check("jxx_r3", rd_v, 64'h5);

      // 3 irmovq R1, cmov not taken, popq %rsp
      set_instr(4'h3, 4'hF, 4'h1, 64'h77, 64'h0, 64'h77, 64'h10A, 1'b0);
      step();
      read_reg(4'h1, rd_v); check("irmov_r1", rd_v, 64'h77);
      set_instr(4'h2, 4'h3, 4'h1, 64'h5, 64'h0, 64'h0, 64'h10C, 1'b0);
      step();
      read_reg(4'h1, rd_v); check("cmov_nt_r1", rd_v, 64'h77);
      check("cmov_pc", bus.pc, 64'h10C);
      set_instr(4'hB, 4'h4, 4'hF, 64'h108, 64'hAA, 64'h0, 64'h10E, 1'b0);
      step();
      read_reg(4'h4, rd_v); check("popq_rsp", rd_v, 64'hAA);

      // 4 call / ret
      set_instr(4'h3, 4'hF, 4'h4, 64'h200, 64'h0, 64'h200, 64'h118, 1'b0);
      step();
      set_instr(4'h8, 4'hF, 4'hF, 64'h1F8, 64'h0, 64'h40, 64'h121, 1'b0);
      #1 check("call_valB", bus.valB, 64'h200);
      step();
      read_reg(4'h4, rd_v); check("call_r4", rd_v, 64'h1F8);
      check("call_pc", bus.pc, 64'h40);
      set_instr(4'h9, 4'hF, 4'hF, 64'h200, 64'h13, 64'h0, 64'h41, 1'b0);
      #1 check("ret_valA", bus.valA, 64'h1F8);
      step();
      check("ret_pc", bus.pc, 64'h13);
      read_reg(4'h4, rd_v); check("ret_r4", rd_v, 64'h200);

      // 5 data fault on mrmovq, then sticky
      set_instr(4'h5, 4'h1, 4'h3, 64'h9, 64'h999, 64'h0, 64'h55, 1'b0);
      bus.dmem_error = 1'b1;
      step();
      bus.dmem_error = 1'b0;
      check("adr_stat", {61'h0, bus.stat}, 64'd3);
      check("adr_halted", {63'h0, bus.halted}, 64'd1);
      check("adr_pc", bus.pc, 64'h13);
      read_reg(4'h1, rd_v); check("adr_r1", rd_v, 64'h77);
      set_instr(4'h3, 4'hF, 4'h1, 64'hDEAD, 64'h0, 64'hDEAD, 64'h60, 1'b0);
      step();
      read_reg(4'h1, rd_v); check("sticky_r1", rd_v, 64'h77);
      check("sticky_pc", bus.pc, 64'h13);
      check("sticky_stat", {61'h0, bus.stat}, 64'd3);

      // 6 reset mid-run, observed before any clock edge
      pulse_reset();
      check("mrst_pc", bus.pc, T_RESET_PC);
      check("mrst_stat", {61'h0, bus.stat}, 64'd1);
      check("mrst_cc", {61'h0, bus.cc_zf, bus.cc_sf, bus.cc_of}, 64'd4);
      read_reg(4'h1, rd_v); check("mrst_r1", rd_v, 64'h0);
      read_reg(4'h4, rd_v); check("mrst_r4", rd_v, T_RSP_INIT);
      rst_n = 1'b1;

      // step_en=0 edge commits nothing
      set_instr(4'h3, 4'hF, 4'h5, 64'h1, 64'h0, 64'h1, 64'h2000, 1'b0);
      @(posedge clk); #1;
      read_reg(4'h5, rd_v); check("noen_r5", rd_v, 64'h0);
      check("noen_pc", bus.pc, T_RESET_PC);

      // illegal icode
      set_instr(4'hC, 4'hF, 4'h5, 64'h1, 64'h0, 64'h0, 64'h2000, 1'b0);
      step();
      check("ins_stat", {61'h0, bus.stat}, 64'd4);
      check("ins_pc", bus.pc, T_RESET_PC);
      read_reg(4'h5, rd_v); check("ins_r5", rd_v, 64'h0);

      // halt
      pulse_reset();
      rst_n = 1'b1;
      set_instr(4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 64'h1001, 1'b0);
      step();
      check("hlt_stat", {61'h0, bus.stat}, 64'd2);
      check("hlt_halted", {63'h0, bus.halted}, 64'd1);
      check("hlt_pc", bus.pc, T_RESET_PC);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
